// File: rtl/dataflow_stall_monitor.sv
// Dataflow deadlock monitor: per-process stall counters plus a wait-for graph
// walker that confirms and latches a cycle of mutually blocked processes.
module dataflow_stall_monitor #(
    parameter int N      = 3,
    parameter int IDXW   = 2,
    parameter int THRESH = 16,
    parameter int CW     = 16
) (
    input  logic                dl_clock,
    input  logic                dl_reset,
    input  logic                all_finish,
    input  logic [N-1:0]        proc_blk,
    input  logic [N*IDXW-1:0]   proc_dep,
    output logic                dl_detect,
    output logic [IDXW-1:0]     dl_origin,
    output logic [N-1:0]        dl_cycle_mask,
    output logic [IDXW:0]       dl_cycle_len,
    output logic [CW-1:0]       stall_max
);

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } state_e;

    localparam logic [CW-1:0]   CNT_MAX = '1;
    localparam logic [CW-1:0]   THR     = CW'(THRESH);
    localparam logic [IDXW:0]   HOP1    = (IDXW+1)'(1);
    localparam logic [IDXW-1:0] IDX1    = IDXW'(1);
    localparam logic [N-1:0]    BIT0    = N'(1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q [N];
    logic [CW-1:0]       cnt_d [N];
    logic [IDXW-1:0]     scan_ptr_q, scan_ptr_d;
    logic [IDXW-1:0]     origin_q, origin_d;
    logic [IDXW-1:0]     cur_q, cur_d;
    logic [N-1:0]        mask_q, mask_d;
    logic [IDXW:0]       hops_q, hops_d;
    logic                det_q, det_d;
    logic [IDXW-1:0]     out_origin_q, out_origin_d;
    logic [N-1:0]        out_mask_q, out_mask_d;
    logic [IDXW:0]       out_len_q, out_len_d;
    logic [CW-1:0]       stall_max_q, stall_max_d;

    logic [N-1:0]        qual;
    logic                cur_qual;
    logic                cur_seen;
    logic                cur_valid;
    logic                o_qual;
    logic [IDXW-1:0]     cur_dep;
    logic                sel_found;
    logic [IDXW-1:0]     sel;
    logic [IDXW-1:0]     sel_dep;
    int                  scan_idx;
    logic                abort;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            qual[i] = proc_blk[i] && (cnt_q[i] >= THR);
        end
    end

    // Lookups keyed by the walk pointer; an out-of-range pointer matches nothing.
    always_comb begin
        cur_qual  = 1'b0;
        cur_seen  = 1'b0;
        o_qual    = 1'b0;
        cur_dep   = '0;
        cur_valid = (int'(cur_q) < N);
        for (int i = 0; i < N; i++) begin
            if (cur_q == IDXW'(i)) begin
                cur_qual = qual[i];
                cur_seen = mask_q[i];
                cur_dep  = proc_dep[i*IDXW +: IDXW];
            end
            if (origin_q == IDXW'(i)) begin
                o_qual = qual[i];
            end
        end
    end

    // Rotating priority scan so a stuck non-cycle process cannot starve others.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        sel_dep   = '0;
        scan_idx  = 0;
        for (int k = 0; k < N; k++) begin
            scan_idx = int'(scan_ptr_q) + k;
            if (scan_idx >= N) begin
                scan_idx = scan_idx - N;
            end
            if (!sel_found && qual[scan_idx]) begin
                sel_found = 1'b1;
                sel       = IDXW'(scan_idx);
                sel_dep   = proc_dep[scan_idx*IDXW +: IDXW];
            end
        end
    end

    always_comb begin
        stall_max_d = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q[i] > stall_max_d) begin
                stall_max_d = cnt_q[i];
            end
            if (all_finish) begin
                cnt_d[i] = '0;
            end else if (state_q == DONE) begin
                cnt_d[i] = cnt_q[i];
            end else if (proc_blk[i]) begin
                cnt_d[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + 1'b1;
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        scan_ptr_d   = scan_ptr_q;
        origin_d     = origin_q;
        cur_d        = cur_q;
        mask_d       = mask_q;
        hops_d       = hops_q;
        det_d        = det_q;
        out_origin_d = out_origin_q;
        out_mask_d   = out_mask_q;
        out_len_d    = out_len_q;
        abort        = 1'b0;
        if (all_finish) begin
            state_d      = IDLE;
            det_d        = 1'b0;
            out_origin_d = '0;
            out_mask_d   = '0;
            out_len_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        origin_d = sel;
                        cur_d    = sel_dep;
                        mask_d   = BIT0 << sel;
                        hops_d   = HOP1;
                        state_d  = WALK;
                    end
                end
                WALK: begin
                    if (!o_qual || !cur_valid || !cur_qual) begin
                        abort = 1'b1;
                    end else if (cur_q == origin_q) begin
                        state_d = DONE;
                    end else if (cur_seen) begin
                        abort = 1'b1;
                    end else begin
                        mask_d = mask_q | (BIT0 << cur_q);
                        cur_d  = cur_dep;
                        hops_d = hops_q + HOP1;
                    end
                    if (abort) begin
                        state_d = IDLE;
                        if (int'(origin_q) + 1 >= N) begin
                            scan_ptr_d = '0;
                        end else begin
                            scan_ptr_d = origin_q + IDX1;
                        end
                    end
                end
                DONE: begin
                    det_d        = 1'b1;
                    out_origin_d = origin_q;
                    out_mask_d   = mask_q;
                    out_len_d    = hops_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge dl_clock) begin
        if (dl_reset) begin
            state_q      <= IDLE;
            scan_ptr_q   <= '0;
            origin_q     <= '0;
            cur_q        <= '0;
            mask_q       <= '0;
            hops_q       <= '0;
            det_q        <= 1'b0;
            out_origin_q <= '0;
            out_mask_q   <= '0;
            out_len_q    <= '0;
            stall_max_q  <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            scan_ptr_q   <= scan_ptr_d;
            origin_q     <= origin_d;
            cur_q        <= cur_d;
            mask_q       <= mask_d;
            hops_q       <= hops_d;
            det_q        <= det_d;
            out_origin_q <= out_origin_d;
            out_mask_q   <= out_mask_d;
            out_len_q    <= out_len_d;
            stall_max_q  <= stall_max_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign dl_detect     = det_q;
    assign dl_origin     = out_origin_q;
    assign dl_cycle_mask = out_mask_q;
    assign dl_cycle_len  = out_len_q;
    assign stall_max     = stall_max_q;

endmodule

// File: tb/tb_dataflow_stall_monitor.sv
// Bench for dataflow_stall_monitor: directed scenarios with fixed expectations
// plus random traffic compared against a graph-walk reference model.
module tb_dataflow_stall_monitor;

    localparam int N      = 3;
    localparam int IDXW   = 2;
    localparam int THRESH = 16;
    localparam int CW     = 16;
    localparam int SATV   = (1 << CW) - 1;

    logic                dl_clock;
    logic                dl_reset;
    logic                all_finish;
    logic [N-1:0]        proc_blk;
    logic [N*IDXW-1:0]   proc_dep;
    logic                dl_detect;
    logic [IDXW-1:0]     dl_origin;
    logic [N-1:0]        dl_cycle_mask;
    logic [IDXW:0]       dl_cycle_len;
    logic [CW-1:0]       stall_max;

    int checks = 0;
    int errors = 0;

    dataflow_stall_monitor #(
        .N(N), .IDXW(IDXW), .THRESH(THRESH), .CW(CW)
    ) dut (
        .dl_clock(dl_clock),
        .dl_reset(dl_reset),
        .all_finish(all_finish),
        .proc_blk(proc_blk),
        .proc_dep(proc_dep),
        .dl_detect(dl_detect),
        .dl_origin(dl_origin),
        .dl_cycle_mask(dl_cycle_mask),
        .dl_cycle_len(dl_cycle_len),
        .stall_max(stall_max)
    );

    initial begin
        dl_clock = 1'b0;
        forever #5 dl_clock = ~dl_clock;
    end

    // Reference model: wait-for graph walk using an explicit path list.
    int m_cnt [N];
    int m_state;
    int m_ptr;
    int m_o;
    int m_cur;
    int m_path [$];
    int m_det;
    int m_org;
    int m_mask;
    int m_len;
    int m_smax;

    function automatic int dep_of(int i);
        logic [N*IDXW-1:0] t;
        t = proc_dep >> (i * IDXW);
        return int'(t[IDXW-1:0]);
    endfunction

    function automatic bit on_path(int v);
        foreach (m_path[k]) begin
            if (m_path[k] == v) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit qual [N];
        bit abort_w;
        int j;
        if (dl_reset) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_state = 0; m_ptr = 0; m_o = 0; m_cur = 0;
            m_path.delete();
            m_det = 0; m_org = 0; m_mask = 0; m_len = 0; m_smax = 0;
            return;
        end
        m_smax = 0;
        foreach (m_cnt[i]) begin
            if (m_cnt[i] > m_smax) m_smax = m_cnt[i];
            qual[i] = proc_blk[i] && (m_cnt[i] >= THRESH);
        end
        if (all_finish) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_state = 0;
            m_det = 0; m_org = 0; m_mask = 0; m_len = 0;
            return;
        end
        if (m_state != 2) begin
            foreach (m_cnt[i]) begin
                if (!proc_blk[i]) m_cnt[i] = 0;
                else if (m_cnt[i] < SATV) m_cnt[i] = m_cnt[i] + 1;
            end
        end
        abort_w = 1'b0;
        if (m_state == 0) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (qual[j]) begin
                    m_o = j;
                    m_path.delete();
                    m_path.push_back(j);
                    m_cur = dep_of(j);
                    m_state = 1;
                    break;
                end
            end
        end else if (m_state == 1) begin
            if (!qual[m_o] || m_cur >= N) abort_w = 1'b1;
            else if (!qual[m_cur]) abort_w = 1'b1;
            else if (m_cur == m_o) m_state = 2;
            else if (on_path(m_cur)) abort_w = 1'b1;
            else begin
                m_path.push_back(m_cur);
                m_cur = dep_of(m_cur);
            end
            if (abort_w) begin
                m_state = 0;
                m_ptr = (m_o + 1) % N;
            end
        end else begin
            m_det = 1;
            m_org = m_o;
            m_mask = 0;
            foreach (m_path[k]) m_mask = m_mask | (1 << m_path[k]);
            m_len = m_path.size();
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge dl_clock);
        #1;
    endtask

    task automatic do_reset();
        dl_reset = 1'b1;
        all_finish = 1'b0;
        proc_blk = '0;
        proc_dep = '0;
        tick();
        dl_reset = 1'b0;
    endtask

    task automatic wait_detect(output int edges, input int limit);
        edges = 0;
        while (!dl_detect && edges < limit) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        dl_reset = 1'b1;
        all_finish = 1'b1;
        proc_blk = '1;
        proc_dep = '0;
        tick();
        tick();
        dl_reset = 1'b0;
        all_finish = 1'b0;
        checks++;
        if (dl_detect !== 1'b0) begin
            errors++; $display("FAIL reset_detect got %b want 0", dl_detect);
        end
        checks++;
        if (dl_origin !== '0) begin
            errors++; $display("FAIL reset_origin got %0d want 0", dl_origin);
        end
        checks++;
        if (dl_cycle_mask !== '0) begin
            errors++; $display("FAIL reset_mask got %b want 0", dl_cycle_mask);
        end
        checks++;
        if (dl_cycle_len !== '0) begin
            errors++; $display("FAIL reset_len got %0d want 0", dl_cycle_len);
        end
        checks++;
        if (stall_max !== '0) begin
            errors++; $display("FAIL reset_stall_max got %0d want 0", stall_max);
        end
    endtask

    task automatic test_two_cycle();
        int edges;
        do_reset();
        proc_blk = 3'b011;
        proc_dep = {2'd0, 2'd0, 2'd1};
        wait_detect(edges, 60);
        checks++;
        if (edges != 20) begin
            errors++; $display("FAIL two_latency got %0d want 20", edges);
        end
        checks++;
        if (dl_origin !== 2'd0 || dl_cycle_mask !== 3'b011 || dl_cycle_len !== 3'd2) begin
            errors++;
            $display("FAIL two_result got o=%0d m=%b l=%0d want o=0 m=011 l=2",
                     dl_origin, dl_cycle_mask, dl_cycle_len);
        end
        for (int c = 0; c < 6; c++) begin
            proc_blk = N'($urandom);
            proc_dep = (N*IDXW)'($urandom);
            tick();
        end
        checks++;
        if (dl_detect !== 1'b1 || dl_origin !== 2'd0 || dl_cycle_mask !== 3'b011 ||
            dl_cycle_len !== 3'd2 || stall_max !== CW'(19)) begin
            errors++;
            $display("FAIL done_freeze got d=%b o=%0d m=%b l=%0d s=%0d want 1 0 011 2 19",
                     dl_detect, dl_origin, dl_cycle_mask, dl_cycle_len, stall_max);
        end
        all_finish = 1'b1;
        tick();
        all_finish = 1'b0;
        checks++;
        if (dl_detect !== 1'b0 || dl_origin !== '0 || dl_cycle_mask !== '0 ||
            dl_cycle_len !== '0) begin
            errors++;
            $display("FAIL finish_clear got d=%b o=%0d m=%b l=%0d want all 0",
                     dl_detect, dl_origin, dl_cycle_mask, dl_cycle_len);
        end
        tick();
        checks++;
        if (stall_max !== '0) begin
            errors++; $display("FAIL finish_cnt got %0d want 0", stall_max);
        end
    endtask

    task automatic test_three_cycle();
        int edges;
        do_reset();
        proc_blk = 3'b111;
        proc_dep = {2'd0, 2'd2, 2'd1};
        wait_detect(edges, 60);
        checks++;
        if (edges != 21) begin
            errors++; $display("FAIL three_latency got %0d want 21", edges);
        end
        checks++;
        if (dl_origin !== 2'd0 || dl_cycle_mask !== 3'b111 || dl_cycle_len !== 3'd3) begin
            errors++;
            $display("FAIL three_result got o=%0d m=%b l=%0d want o=0 m=111 l=3",
                     dl_origin, dl_cycle_mask, dl_cycle_len);
        end
    endtask

    task automatic test_chain();
        int edges;
        do_reset();
        proc_blk = 3'b111;
        proc_dep = {2'd1, 2'd2, 2'd1};
        wait_detect(edges, 60);
        checks++;
        if (edges != 24) begin
            errors++; $display("FAIL chain_latency got %0d want 24", edges);
        end
        checks++;
        if (dl_origin !== 2'd1 || dl_cycle_mask !== 3'b110 || dl_cycle_len !== 3'd2) begin
            errors++;
            $display("FAIL chain_result got o=%0d m=%b l=%0d want o=1 m=110 l=2",
                     dl_origin, dl_cycle_mask, dl_cycle_len);
        end
    endtask

    task automatic test_drop();
        bit seen;
        do_reset();
        proc_blk = 3'b011;
        proc_dep = {2'd0, 2'd0, 2'd1};
        for (int c = 0; c < 17; c++) tick();
        proc_blk = 3'b001;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (dl_detect) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL drop_no_detect got 1 want 0");
        end
        proc_blk = 3'b010;
        tick();
        tick();
        checks++;
        if (stall_max !== CW'(1)) begin
            errors++; $display("FAIL drop_cnt_clear got %0d want 1", stall_max);
        end
    endtask

    task automatic test_reset_mid_walk();
        int edges;
        do_reset();
        proc_blk = 3'b111;
        proc_dep = {2'd0, 2'd2, 2'd1};
        for (int c = 0; c < 18; c++) tick();
        dl_reset = 1'b1;
        all_finish = 1'b1;
        tick();
        dl_reset = 1'b0;
        all_finish = 1'b0;
        checks++;
        if (dl_detect !== 1'b0 || dl_cycle_mask !== '0 || dl_cycle_len !== '0 ||
            dl_origin !== '0 || stall_max !== '0) begin
            errors++;
            $display("FAIL midwalk_reset got d=%b m=%b l=%0d s=%0d want all 0",
                     dl_detect, dl_cycle_mask, dl_cycle_len, stall_max);
        end
        wait_detect(edges, 60);
        checks++;
        if (edges != 21 || dl_cycle_mask !== 3'b111) begin
            errors++;
            $display("FAIL midwalk_redetect got e=%0d m=%b want e=21 m=111",
                     edges, dl_cycle_mask);
        end
    endtask

    task automatic test_saturation();
        bit seen;
        int edges;
        do_reset();
        proc_blk = 3'b100;
        proc_dep = {2'd3, 2'd0, 2'd0};
        seen = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            tick();
            if (dl_detect) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL bad_dep_detect got 1 want 0");
        end
        checks++;
        if (stall_max !== CW'(SATV)) begin
            errors++; $display("FAIL saturate got %0d want %0d", stall_max, SATV);
        end
        proc_dep = {2'd2, 2'd0, 2'd0};
        wait_detect(edges, 20);
        checks++;
        if (dl_detect !== 1'b1 || dl_origin !== 2'd2 || dl_cycle_mask !== 3'b100 ||
            dl_cycle_len !== 3'd1) begin
            errors++;
            $display("FAIL self_loop got d=%b o=%0d m=%b l=%0d want 1 2 100 1",
                     dl_detect, dl_origin, dl_cycle_mask, dl_cycle_len);
        end
    endtask

    task automatic test_random();
        int hold;
        int bad;
        do_reset();
        bad = 0;
        for (int s = 0; s < 70; s++) begin
            for (int i = 0; i < N; i++) proc_blk[i] = ($urandom_range(0, 3) != 0);
            proc_dep = (N*IDXW)'($urandom);
            all_finish = ($urandom_range(0, 9) == 0);
            dl_reset = ($urandom_range(0, 15) == 0);
            hold = $urandom_range(5, 45);
            for (int c = 0; c < hold; c++) begin
                tick();
                all_finish = 1'b0;
                dl_reset = 1'b0;
                checks++;
                if (int'(dl_detect) !== m_det || int'(dl_origin) !== m_org ||
                    int'(dl_cycle_mask) !== m_mask || int'(dl_cycle_len) !== m_len ||
                    int'(stall_max) !== m_smax) begin
                    errors++;
                    if (bad < 10)
                        $display("FAIL random seg=%0d got d=%b o=%0d m=%b l=%0d s=%0d want d=%0d o=%0d m=%0d l=%0d s=%0d",
                                 s, dl_detect, dl_origin, dl_cycle_mask, dl_cycle_len,
                                 stall_max, m_det, m_org, m_mask, m_len, m_smax);
                    bad++;
                end
            end
        end
    endtask

    initial begin
        dl_reset = 1'b1;
        all_finish = 1'b0;
        proc_blk = '0;
        proc_dep = '0;
        test_reset();
        test_two_cycle();
        test_three_cycle();
        test_chain();
        test_drop();
        test_reset_mid_walk();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
